// File: rtl/sram_lht_pkg.sv
// Shared constants and state encoding for the LHT SRAM port-0 sequencer.
package sram_lht_pkg;

    localparam int LHT_ADDR_W = 8;
    localparam int LHT_DATA_W = 4;
    localparam int LHT_DEPTH  = 256;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } lht_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or
// after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] index
);

    int unsigned          cand;
    logic [ID_WIDTH-1:0]  cidx;
    logic                 found;

    // Scan from ptr upwards and take the first asserted valid.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % 32'(NUM_REQ);
            cidx = ID_WIDTH'(cand);
            if (!found && valid[cidx]) begin
                grant[cidx] = 1'b1;
                index       = cidx;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_lht_arb.sv
// Port-0 sequencer for the 256x4 LHT SRAM: clears the array after reset or on
// request, then round-robins NUM_REQ requesters onto the port and returns
// tagged read data. Any write is followed by a dummy read when the port would
// otherwise idle, so the macro never replays a stale latched write.
module sram_lht_arb
    import sram_lht_pkg::*;
#(
    parameter int                    NUM_REQ     = 4,
    parameter int                    ADDR_WIDTH  = LHT_ADDR_W,
    parameter int                    DATA_WIDTH  = LHT_DATA_W,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter int                    ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_req,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic                             rsp_valid,
    output logic [ID_WIDTH-1:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             init_done,
    output logic                             busy,
    output logic                             sram_csb,
    output logic                             sram_web,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [DATA_WIDTH-1:0]            sram_din,
    input  logic [DATA_WIDTH-1:0]            sram_dout
);

    lht_state_t             state;
    logic [ADDR_WIDTH-1:0]  clr_cnt;
    logic [ID_WIDTH-1:0]    rr_ptr;
    logic [ID_WIDTH-1:0]    gnt_idx;
    logic [ID_WIDTH-1:0]    next_ptr;
    logic [NUM_REQ-1:0]     gnt;
    logic                   arb_en;
    logic                   xfer;
    logic                   xfer_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   wr_pend;
    logic [ADDR_WIDTH-1:0]  wr_addr;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .index (gnt_idx)
    );

    // Grant only in RUN and never in a cycle that requests a clear.
    always_comb begin
        arb_en    = (state == RUN) && !clear_req;
        req_ready = arb_en ? gnt : '0;
        xfer      = |(req_valid & req_ready);
        xfer_we   = req_we[gnt_idx];
        sel_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        next_ptr  = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        busy      = (state != RUN);
        rsp_data  = sram_dout;
    end

    // Port-0 drive; held idle while reset is asserted.
    always_comb begin
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_addr = '0;
        sram_din  = '0;
        if (rst_n) begin
            case (state)
                CLEAR: begin
                    sram_csb  = 1'b0;
                    sram_web  = 1'b0;
                    sram_addr = clr_cnt;
                    sram_din  = CLEAR_VALUE;
                end
                FLUSH: begin
                    sram_csb  = 1'b0;
                    sram_addr = '1;
                end
                RUN: begin
                    if (xfer) begin
                        sram_csb  = 1'b0;
                        sram_web  = ~xfer_we;
                        sram_addr = sel_addr;
                        sram_din  = sel_wdata;
                    end else if (wr_pend) begin
                        sram_csb  = 1'b0;
                        sram_addr = wr_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clear / flush / run sequencing and the sticky init flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) state <= FLUSH;
                end
                FLUSH: begin
                    state     <= RUN;
                    init_done <= 1'b1;
                end
                RUN: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Pointer advance, read response tagging and pending-write tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
        end else begin
            rsp_valid <= xfer & ~xfer_we;
            wr_pend   <= xfer & xfer_we;
            if (xfer) begin
                rr_ptr  <= next_ptr;
                rsp_id  <= gnt_idx;
                wr_addr <= sel_addr;
            end
        end
    end

endmodule

// File: tb/tb_sram_lht_arb.sv
// Directed bench for sram_lht_arb with a behavioural port-0 macro model whose
// write enable stays latched until the next selected access.
module tb_sram_lht_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_req;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        init_done;
    logic        busy;
    logic        sram_csb;
    logic        sram_web;
    logic [7:0]  sram_addr;
    logic [3:0]  sram_din;
    logic [3:0]  sram_dout;

    sram_lht_arb #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .busy      (busy),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    // SRAM model: inputs captured on a selected edge; a latched write keeps
    // committing on every edge until a later access replaces it.
    logic [3:0] mem [0:255];
    logic       m_web  = 1'b1;
    logic [7:0] m_addr = '0;
    logic [3:0] m_din  = '0;
    logic       m_fill;
    logic       p1_we;
    logic [7:0] p1_addr;
    logic [3:0] p1_din;

    always @(posedge clk) begin
        if (m_fill) for (int i = 0; i < 256; i++) mem[i] <= 4'(i) | 4'h8;
        if (!m_web) mem[m_addr] <= m_din;
        if (p1_we) mem[p1_addr] <= p1_din;
        if (!sram_csb) begin
            m_web  <= sram_web;
            m_addr <= sram_addr;
            m_din  <= sram_din;
        end
    end
    assign sram_dout = mem[m_addr];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] ref_mem [0:255];
    logic [5:0] sb [$];
    logic [5:0] sb_e;
    int         exp_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest queued read.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_spurious", 32'(sb.size()), 32'd1);
            end else begin
                sb_e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(sb_e[5:4]));
                chk("rsp_data", 32'(rsp_data), 32'(sb_e[3:0]));
            end
        end
    end

    task automatic chk_reset();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_csb", 32'(sram_csb), 32'h1);
        chk("rst_web", 32'(sram_web), 32'h1);
    endtask

    // Called at the negedge of the first clear cycle; returns one cycle into RUN.
    task automatic check_clear(input logic exp_init);
        for (int k = 0; k < 256; k++) begin
            req_valid = '1;
            req_we    = '0;
            #1;
            chk("clr_bus", {sram_csb, sram_web, sram_addr, sram_din}, {18'h0, 1'b0, 1'b0, 8'(k), 4'h0});
            chk("clr_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        #1;
        chk("flush_bus", {sram_csb, sram_web, sram_addr}, {22'h0, 1'b0, 1'b1, 8'hFF});
        chk("flush_ready", 32'(req_ready), 32'h0);
        chk("flush_busy", 32'(busy), 32'h1);
        chk("flush_init", 32'(init_done), 32'(exp_init));
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("run_init", 32'(init_done), 32'h1);
        chk("run_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 4'h0;
        @(negedge clk);
    endtask

    // One RUN cycle: drive, check the grant and port drive, update the model.
    task automatic cycle_req(input logic [3:0] v, input logic [3:0] we,
                             input logic [31:0] a, input logic [15:0] d);
        int         g;
        logic [3:0] exp_ready;
        logic [7:0] ga;
        logic [3:0] gd;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            if (g < 0 && v[(exp_ptr + i) % 4]) g = (exp_ptr + i) % 4;
        end
        exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        if (g >= 0) begin
            ga = a[g*8 +: 8];
            gd = d[g*4 +: 4];
            if (we[g]) begin
                chk("wr_bus", {sram_csb, sram_web, sram_addr, sram_din}, {18'h0, 1'b0, 1'b0, ga, gd});
                ref_mem[ga] = gd;
            end else begin
                chk("rd_bus", {sram_csb, sram_web, sram_addr}, {22'h0, 1'b0, 1'b1, ga});
                sb.push_back({2'(g), ref_mem[ga]});
            end
            exp_ptr = (g + 1) % 4;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_req(4'h0, 4'h0, 32'h0, 16'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        clear_req = 1'b0;
        req_valid = '1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        p1_we     = 1'b0;
        p1_addr   = '0;
        p1_din    = '0;
        m_fill    = 1'b1;
        exp_ptr   = 0;
        @(negedge clk);
        m_fill = 1'b0;
        #1;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_clear(1'b0);

        // Read after init.
        cycle_req(4'b0001, 4'b0000, 32'h0000_003C, 16'h0);
        idle(1);

        // All four writing, then all four reading back-to-back.
        for (int i = 0; i < 4; i++)
            cycle_req(4'hF, 4'hF, 32'h0403_0201, 16'h4321);
        for (int i = 0; i < 8; i++)
            cycle_req(4'hF, 4'h0, 32'h0403_0201, 16'h0);
        idle(2);

        // Write from requester 2 followed immediately by a read from requester 1.
        cycle_req(4'b0100, 4'b0100, 32'h0010_0000, 16'h0A00);
        cycle_req(4'b0010, 4'b0000, 32'h0000_1000, 16'h0);
        idle(2);

        // Lone write, then idle: dummy read, then a port-1 write that must survive.
        cycle_req(4'b1000, 4'b1000, 32'h2000_0000, 16'h5000);
        req_valid = '0;
        #1;
        chk("wflush_bus", {sram_csb, sram_web, sram_addr}, {22'h0, 1'b0, 1'b1, 8'h20});
        @(negedge clk);
        #1;
        chk("idle_csb", 32'(sram_csb), 32'h1);
        @(negedge clk);
        p1_we   = 1'b1;
        p1_addr = 8'h20;
        p1_din  = 4'h3;
        ref_mem[8'h20] = 4'h3;
        @(negedge clk);
        p1_we = 1'b0;
        idle(2);
        cycle_req(4'b0001, 4'b0000, 32'h0000_0020, 16'h0);
        idle(1);

        // Clear requested while a read response is due.
        cycle_req(4'b0001, 4'b0000, 32'h0000_0001, 16'h0);
        clear_req = 1'b1;
        req_valid = '1;
        #1;
        chk("clrreq_ready", 32'(req_ready), 32'h0);
        chk("clrreq_csb", 32'(sram_csb), 32'h1);
        @(negedge clk);
        clear_req = 1'b0;
        check_clear(1'b1);
        for (int a = 0; a < 256; a++)
            cycle_req(4'b0001, 4'b0000, 32'(a), 16'h0);
        idle(2);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        // Reset pulse in the middle of a clear.
        clear_req = 1'b1;
        req_valid = '0;
        @(negedge clk);
        clear_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            req_valid = '1;
            #1;
            chk("clr2_addr", 32'(sram_addr), 32'(k));
            @(negedge clk);
        end
        #1;
        chk("clr2_at100", {sram_csb, sram_web, sram_addr}, {22'h0, 1'b0, 1'b0, 8'd100});
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ptr = 0;
        check_clear(1'b0);
        cycle_req(4'hF, 4'h0, 32'h3C3C_3C3C, 16'h0);
        idle(2);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_lht_arb.md
Name: sram_lht_arb

Overview:
- Sequencer and arbiter for port 0 of the 256x4 dual-port LHT SRAM (active-low csb/web; address, data and write enable registered inside the macro).
- On reset, and on request, it clears every entry to CLEAR_VALUE. After that it round-robins NUM_REQ valid/ready requesters onto the port and returns read data tagged with the requester ID.
- Port 1 stays owned by its existing user. This block also guarantees that port 0 never repeats a stale write.

Parameters:
- NUM_REQ, 4, number of requesters.
- ADDR_WIDTH, 8, SRAM address width (depth = 2^ADDR_WIDTH).
- DATA_WIDTH, 4, SRAM word width.
- CLEAR_VALUE, 0, word written to each entry during a clear.
- ID_WIDTH, $clog2(NUM_REQ), width of the response tag.

Ports:
- clk  in  1  single clock; also drives SRAM clk0.
- rst_n  in  1  reset, asynchronous, active-low.
- clear_req  in  1  pulse that starts a full clear; honoured only in RUN.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- rsp_valid  out  1  read data valid.
- rsp_id  out  ID_WIDTH  index of the requester that issued the read.
- rsp_data  out  DATA_WIDTH  read data.
- init_done  out  1  high once the first clear has completed.
- busy  out  1  high in CLEAR or FLUSH.
- sram_csb  out  1  to csb0.
- sram_web  out  1  to web0.
- sram_addr  out  ADDR_WIDTH  to addr0.
- sram_din  out  DATA_WIDTH  to din0.
- sram_dout  in  DATA_WIDTH  from dout0.

Behaviour:
- Reset values: state=CLEAR, clr_cnt=0, rr_ptr=0, rsp_valid=0, rsp_id=0, init_done=0, busy=1, req_ready=0, sram_csb=1, sram_web=1.
- Reset mid-operation restarts the clear from address 0 and sets init_done back to 0.
- FSM states:
  - CLEAR: each cycle drives csb=0, web=0, addr=clr_cnt, din=CLEAR_VALUE; clr_cnt increments. After the write to 2^ADDR_WIDTH-1 go to FLUSH.
  - FLUSH: one cycle of csb=0, web=1, addr=last address. Next state RUN. On leaving FLUSH, init_done goes to 1 and stays 1 until reset.
  - RUN: arbitration, described below.
- CLEAR takes exactly 2^ADDR_WIDTH cycles. init_done rises on the clock edge 257 cycles after reset release; busy falls on the same edge.
- Arbitration in RUN: the grant goes to the first valid requester starting at rr_ptr and wrapping modulo NUM_REQ. req_ready is that one-hot grant and depends combinationally on req_valid. A transfer is valid&ready. On a transfer, rr_ptr becomes grant index + 1, wrapping NUM_REQ-1 to 0.
- Transfer in cycle t: drive csb=0, web=~req_we, addr and din from the granted slice.
  - Write: commits at the edge ending cycle t+1.
  - Read: rsp_valid=1 and rsp_id=grant index in cycle t+1 (both registered). rsp_data passes sram_dout through combinationally in that cycle.
  - Throughput is one access per cycle; reads issued back-to-back give back-to-back responses.
- Write-flush rule: if cycle t carried a write and cycle t+1 has no transfer, drive a dummy read in t+1 (csb=0, web=1, same addr). It produces no response. This clears the macro's latched web so the write does not repeat and clobber port 1 writes.
- Read-after-write to the same address in consecutive cycles returns the new data; no bypass is needed.
- With no transfer and no pending flush: csb=1.
- clear_req in RUN: no grant in that cycle; enter CLEAR next. A response already due in that cycle is still delivered. Any write issued in the previous cycle is flushed by the first clear write. clear_req in CLEAR or FLUSH is ignored.
- req_ready=0 in CLEAR and FLUSH, regardless of req_valid.

Decomposition:
- Shared package sram_lht_pkg holds: LHT_ADDR_W=8, LHT_DATA_W=4, LHT_DEPTH=256, and the state enum {CLEAR, FLUSH, RUN}.
- One sub-module, rr_arbiter: parameter NUM_REQ; inputs valid vector and ptr; outputs one-hot grant and encoded index. Combinational, reused elsewhere.

Test Plan:
- Release reset, no requests -> 256 consecutive writes of 0 to addresses 0..255, then one dummy read at 255. init_done=1 and busy=0 from edge 257. A read of addr 0x3C then returns 0.
- All 4 requesters hold valid=1 with reads -> grants 0,1,2,3,0,...; one rsp per cycle; rsp_id follows the same sequence one cycle later.
- Requester 2 writes 0xA to 0x10 in cycle t; requester 1 reads 0x10 in t+1 -> rsp_valid=1 in t+2 with data 0xA and rsp_id=1.
- Single write of 0x5 to 0x20, then idle -> next cycle shows csb=0, web=1, addr=0x20. A port 1 write of 0x3 to 0x20 two cycles later persists.
- clear_req asserted in the same cycle a read is outstanding -> that response is still delivered. 256 clear writes follow, with req_ready=0 throughout; afterwards every address reads 0.
- rst_n pulsed low during CLEAR at clr_cnt=100 -> outputs return to reset values immediately; the clear restarts at 0; init_done=1 257 cycles after release.
